bcd_down_counter: RTL

- Loadable multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the team's mod-10 up-counter with carry.
- Counts down one step per qualified clk_en tick and propagates borrow digit to digit.
- Raises a one-cycle done pulse on reaching zero.
- Sits between the control FSM (which loads and starts it) and the seven-segment display path (which consumes cnt_out).

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_dec.sv | 21 ++
 rtl/bcd_down_counter.sv | 111 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD countdown timer.
package bcd_pkg;

  // Control FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  // BCD digit limits
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Bundled per-cycle control request from the control FSM
  typedef struct packed {
    logic clr;
    logic load;
    logic pause;
    logic start;
    logic clk_en;
  } ctrl_t;

  // Force a nibble into the legal BCD range; 0xA..0xF collapse to 9
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit decrementer: a stage of the borrow chain.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       bin,
  output logic [3:0] next_digit,
  output logic       bout
);

  // Decrement when a borrow arrives; 0 wraps to 9 and passes the borrow up
  always_comb begin
    bout       = bin & (digit == BCD_ZERO);
    next_digit = digit;
    if (bin) begin
      if (digit == BCD_ZERO) next_digit = BCD_MAX;
      else                   next_digit = digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown timer with IDLE/RUN/PAUSED control
// and a one-cycle done pulse on reaching zero.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] cnt_out,
  output logic                    bo,
  output logic                    busy,
  output logic                    done
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  ctrl_t ctrl;
  assign ctrl = '{clr: clr, load: load, pause: pause, start: start, clk_en: clk_en};

  logic [NUM_DIGITS-1:0][3:0] cnt, cnt_nxt, cnt_dec, ld_clamped;
  logic [1:0]                 state, state_nxt;
  logic                       done_nxt;
  logic [NUM_DIGITS:0]        borrow;
  logic                       dec_en, is_zero, is_one;

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == CNT_ONE);

  // A decrement is only requested in RUN on a tick that is not overridden
  // by clear, load or pause.
  assign dec_en    = ~ctrl.clr & ~ctrl.load & ~ctrl.pause & ctrl.clk_en & (state == RUN);
  assign borrow[0] = dec_en;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit_dec u_dig (
        .digit      (cnt[g]),
        .bin        (borrow[g]),
        .next_digit (cnt_dec[g]),
        .bout       (borrow[g+1])
      );
      assign ld_clamped[g] = bcd_clamp(load_val[4*g +: 4]);
    end
  endgenerate

  // Next count / state / done: clr > load > pause > start > decrement.
  // A borrow out of the top digit would mean 0 -> all-nines; that result
  // is discarded so the count can never wrap.
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    done_nxt  = 1'b0;
    if (ctrl.clr) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (ctrl.load) begin
      cnt_nxt   = ld_clamped;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // starting from zero would be an instant expiry; ignore it
          if (!ctrl.pause && ctrl.start && !is_zero) state_nxt = RUN;
        end
        RUN: begin
          if (ctrl.pause) begin
            state_nxt = PAUSED;
          end else if (dec_en && !borrow[NUM_DIGITS]) begin
            cnt_nxt = cnt_dec;
            if (is_one) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        PAUSED: begin
          if (ctrl.start && !ctrl.pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered count, state, busy flag and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= done_nxt;
    end
  end

  assign cnt_out = cnt;
  assign bo      = is_zero;

endmodule
